// File: rtl/alu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_MUL    = 4'b0000,
    OP_MULH   = 4'b0001,
    OP_MULHSU = 4'b0010,
    OP_MULHU  = 4'b0011,
    OP_DIV    = 4'b0100,
    OP_DIVU   = 4'b0101,
    OP_REM    = 4'b0110,
    OP_REMU   = 4'b0111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on a 2*WIDTH accumulator.
// Multiply: acc = {partial_hi, multiplier}; add multiplicand into the high half when
// the current multiplier LSB is set, then shift right by one.
// Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract the divisor
// from the high part and keep the difference only when it did not borrow.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // Combinational add-or-pass (multiply) or subtract-and-restore (divide) step
  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_diff = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
    if (!i_is_div) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RISC-V style multiply/divide unit with valid/ready handshakes.
// Operands are reduced to magnitudes on acceptance, iterated one bit per cycle,
// and the sign is restored when the result is captured on entry to DONE.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_md_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_md_data,
  output logic             o_insn_vld
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_div0;
  logic               r_ovf;
  logic [WIDTH-1:0]   r_result;
  logic               r_insn_vld;

  logic               w_accept;
  logic               w_last;
  logic               w_legal;
  logic               w_is_div;
  logic               w_a_sgn;
  logic               w_b_sgn;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_div0;
  logic               w_ovf;
  logic               w_fast;
  logic [2*WIDTH-1:0] w_acc_nxt;

  // Sign restoration and special-case selection for the final result
  function automatic logic [WIDTH-1:0] f_result(
    input logic [3:0]         op,
    input logic [2*WIDTH-1:0] acc,
    input logic               a_neg,
    input logic               b_neg,
    input logic               div0,
    input logic               ovf,
    input logic [WIDTH-1:0]   a_raw
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    prod = (a_neg ^ b_neg) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    case (op)
      OP_MUL:                      f_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: f_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: begin
        if (div0)              f_result = '1;
        else if (ovf)          f_result = a_raw;
        else if (a_neg ^ b_neg) f_result = -quo;
        else                   f_result = quo;
      end
      OP_REM, OP_REMU: begin
        if (div0)       f_result = a_raw;
        else if (ovf)   f_result = '0;
        else if (a_neg) f_result = -rem;
        else            f_result = rem;
      end
      default:          f_result = '0;
    endcase
  endfunction

  // Request decode: signedness per op, magnitudes and fast-path detection
  always_comb begin
    w_accept = i_valid && (r_state == IDLE);
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    w_legal  = !i_md_op[3];
    w_is_div = i_md_op[2];
    w_a_sgn  = (i_md_op == OP_MULH) || (i_md_op == OP_MULHSU) ||
               (i_md_op == OP_DIV)  || (i_md_op == OP_REM);
    w_b_sgn  = (i_md_op == OP_MULH) || (i_md_op == OP_DIV) || (i_md_op == OP_REM);
    w_a_neg  = w_a_sgn && i_operand_a[WIDTH-1];
    w_b_neg  = w_b_sgn && i_operand_b[WIDTH-1];
    w_a_mag  = w_a_neg ? -i_operand_a : i_operand_a;
    w_b_mag  = w_b_neg ? -i_operand_b : i_operand_b;
    w_div0   = w_legal && w_is_div && (i_operand_b == '0);
    w_ovf    = ((i_md_op == OP_DIV) || (i_md_op == OP_REM)) &&
               (i_operand_a == MIN_VAL) && (i_operand_b == '1);
    w_fast   = !w_legal || (FAST_ZERO && (w_div0 || w_ovf));
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_is_div (r_op[2]),
    .o_acc    (w_acc_nxt)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (w_last)   w_state_nxt = DONE;
      DONE:    if (i_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_ready    = (r_state == IDLE);
    o_valid    = (r_state == DONE);
    o_md_data  = r_result;
    o_insn_vld = r_insn_vld;
  end

  // Iteration counter: cleared on acceptance, counts CALC cycles
  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_cnt <= '0;
    else if (w_accept)          r_cnt <= '0;
    else if (r_state == CALC)   r_cnt <= r_cnt + 1'b1;
  end

  // Operand capture on acceptance, one accumulator step per CALC cycle
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op    <= i_md_op;
      r_a_raw <= i_operand_a;
      r_a_neg <= w_a_neg;
      r_b_neg <= w_b_neg;
      r_div0  <= w_div0;
      r_ovf   <= w_ovf;
      if (w_is_div) begin
        r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
        r_opnd <= w_b_mag;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
        r_opnd <= w_a_mag;
      end
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
    end
  end

  // Result capture on entry to DONE; held until the next completion or reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result   <= '0;
      r_insn_vld <= 1'b0;
    end else if (w_accept && w_fast) begin
      r_result   <= f_result(i_md_op, '0, w_a_neg, w_b_neg, w_div0, w_ovf, i_operand_a);
      r_insn_vld <= w_legal;
    end else if ((r_state == CALC) && w_last) begin
      r_result   <= f_result(r_op, w_acc_nxt, r_a_neg, r_b_neg, r_div0, r_ovf, r_a_raw);
      r_insn_vld <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=32, FAST_ZERO=1).
module tb_alu_muldiv;

  logic        clk;
  logic        rst;
  logic [3:0]  md_op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        in_valid;
  logic        out_ready;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] md_data;
  logic        insn_vld;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.WIDTH(32), .FAST_ZERO(1'b1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_md_op     (md_op),
    .i_operand_a (opa),
    .i_operand_b (opb),
    .i_valid     (in_valid),
    .o_ready     (out_ready),
    .o_valid     (out_valid),
    .i_ready     (in_ready),
    .o_md_data   (md_data),
    .o_insn_vld  (insn_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency in cycles, check result, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_iv,
                        input int exp_lat, input bit hold);
    int  lat;
    bit  got;
    @(negedge clk);
    chk({tag, " ready"}, 64'(out_ready), 64'd1);
    md_op    = op;
    opa      = a;
    opb      = b;
    in_valid = 1'b1;
    in_ready = !hold;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    md_op    = 4'($urandom);
    opa      = $urandom;
    opb      = $urandom;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " data"}, 64'(md_data), 64'(exp));
    chk({tag, " insn_vld"}, 64'(insn_vld), 64'(exp_iv));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
        chk({tag, " hold ready"}, 64'(out_ready), 64'd0);
        chk({tag, " hold data"}, 64'(md_data), 64'(exp));
        chk({tag, " hold insn_vld"}, 64'(insn_vld), 64'(exp_iv));
      end
      in_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, " idle ready"}, 64'(out_ready), 64'd1);
    chk({tag, " idle valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int stray;
    rst      = 1'b1;
    md_op    = 4'd0;
    opa      = '0;
    opb      = '0;
    in_valid = 1'b0;
    in_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset data", 64'(md_data), 64'd0);
    chk("reset insn_vld", 64'(insn_vld), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 64'(out_ready), 64'd1);

    run_op("MUL 7*-3",     4'b0000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 33, 1'b0);
    run_op("MULHU -1*-1",  4'b0011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 33, 1'b0);
    run_op("MULH -1*-1",   4'b0001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 1'b1, 33, 1'b0);
    run_op("MULHSU -1*2",  4'b0010, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 1'b1, 33, 1'b0);
    run_op("DIV -7/2",     4'b0100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b1, 33, 1'b0);
    run_op("REM -7%2",     4'b0110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 1'b1, 33, 1'b0);
    run_op("DIVU 100/7",   4'b0101, 32'd100,        32'd7,        32'd14,       1'b1, 33, 1'b0);
    run_op("REMU 100%7",   4'b0111, 32'd100,        32'd7,        32'd2,        1'b1, 33, 1'b0);
    run_op("DIVU 5/0",     4'b0101, 32'd5,          32'd0,        32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run_op("REM 5%0",      4'b0110, 32'd5,          32'd0,        32'd5,        1'b1, 1,  1'b0);
    run_op("DIV MIN/-1",   4'b0100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1, 1,  1'b0);
    run_op("REM MIN%-1",   4'b0110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b1, 1,  1'b0);
    run_op("DIV -100/-7",  4'b0100, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       1'b1, 33, 1'b0);
    run_op("ILLEGAL 1010", 4'b1010, 32'd123,        32'd456,      32'd0,        1'b0, 1,  1'b1);
    run_op("DIVU hold",    4'b0101, 32'd100,        32'd7,        32'd14,       1'b1, 33, 1'b1);

    // Reset in the middle of a divide: operation discarded, unit idle next cycle
    @(negedge clk);
    md_op    = 4'b0100;
    opa      = 32'd1000;
    opb      = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midcalc rst valid", 64'(out_valid), 64'd0);
    chk("midcalc rst ready", 64'(out_ready), 64'd1);
    chk("midcalc rst data", 64'(md_data), 64'd0);
    chk("midcalc rst insn_vld", 64'(insn_vld), 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("midcalc no result", 64'(stray), 64'd0);

    run_op("MUL 3*4",      4'b0000, 32'd3,          32'd4,        32'd12,       1'b1, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
